// File: rtl/spi_stream_ctrl.sv
// Byte-stream front end for an SPI master: TX/RX FIFOs plus a transfer sequencer
// that launches one byte at a time, collects the reply, and enforces an inter-transfer gap.
module spi_stream_ctrl #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       m_start,
    output logic [7:0]                 m_data,
    input  logic                       m_done,
    input  logic [7:0]                 m_rdata,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     tx_count,
    output logic [$clog2(DEPTH):0]     rx_count,
    input  logic                       err_clr,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t          state, state_next;
    logic [WW-1:0]   wait_cnt, wait_next;
    logic [GW-1:0]   gap_cnt, gap_next;

    logic [7:0]      tx_mem [DEPTH];
    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr;
    logic [AW-1:0]   rx_wr_ptr, rx_rd_ptr;

    logic            tx_push, tx_pop, rx_push, rx_pop;
    logic            launch, timeout_hit;

    assign tx_ready = (tx_count < CW'(DEPTH));
    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_mem[rx_rd_ptr];
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = launch;
    assign rx_pop   = rx_valid && rx_ready;
    assign m_start  = (state == START);
    assign busy     = (state != IDLE) || (tx_count != '0);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= m_rdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            gap_cnt  <= gap_next;
        end
    end

    // A transfer only launches when its reply is guaranteed a free RX slot.
    always_comb begin
        state_next  = state;
        wait_next   = wait_cnt;
        gap_next    = gap_cnt;
        launch      = 1'b0;
        rx_push     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                wait_next = '0;
                gap_next  = '0;
                if ((tx_count != '0) && (rx_count < CW'(DEPTH))) begin
                    launch     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                wait_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    rx_push    = 1'b1;
                    gap_next   = '0;
                    state_next = GAP;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    gap_next    = '0;
                    state_next  = GAP;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= 8'h00;
        end else if (launch) begin
            m_data <= tx_mem[tx_rd_ptr];
        end
    end

    // A timeout on the same clock as err_clr keeps the error flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_stream_ctrl.sv
// Directed self-checking bench for spi_stream_ctrl; a small reactive SPI master model
// answers each m_start with m_done carrying (sent byte ^ KEY) after done_delay clocks.
module tb_spi_stream_ctrl;

    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 1023;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam logic [7:0] KEY = 8'h99;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic          m_done = 1'b0;
    logic [7:0]    m_rdata = 8'h00;
    logic          err_clr = 1'b0;
    logic          tx_ready, rx_valid, m_start, busy, timeout_err;
    logic [7:0]    rx_data, m_data;
    logic [CW-1:0] tx_count, rx_count;

    int compared   = 0;
    int mismatched = 0;

    logic       master_en  = 1'b0;
    int         done_delay = 10;
    int         rst_epoch  = 0;
    int         stray_seq  = 0;
    int         stray_done = 0;
    logic [7:0] start_log[$];
    logic [7:0] drain_exp[8];

    spi_stream_ctrl #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .m_start(m_start),
        .m_data(m_data),
        .m_done(m_done),
        .m_rdata(m_rdata),
        .busy(busy),
        .tx_count(tx_count),
        .rx_count(rx_count),
        .err_clr(err_clr),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic popRx();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic waitRxCount(input int n, input int maxc, input string tag);
        int i = 0;
        while (rx_count != CW'(n) && i < maxc) begin
            tick();
            i++;
        end
        if (i >= maxc) checkOutput({tag, "_wait"}, 32'(rx_count), n);
    endtask

    task automatic waitIdle(input int maxc, input string tag);
        int i = 0;
        while (busy && i < maxc) begin
            tick();
            i++;
        end
        if (i >= maxc) checkOutput({tag, "_idle_wait"}, 32'(busy), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_ready"}, 32'(tx_ready), 1);
        checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 0);
        checkOutput({tag, "_m_start"}, 32'(m_start), 0);
        checkOutput({tag, "_m_data"}, 32'(m_data), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 0);
        checkOutput({tag, "_tx_count"}, 32'(tx_count), 0);
        checkOutput({tag, "_rx_count"}, 32'(rx_count), 0);
    endtask

    // Reactive master: answers m_start, or emits an unsolicited m_done on request.
    always begin : master
        int ep;
        @(posedge clk);
        #1;
        if (stray_seq != stray_done) begin
            stray_done = stray_seq;
            m_rdata = 8'hEE;
            m_done  = 1'b1;
            @(posedge clk);
            #1;
            m_done = 1'b0;
        end else if (master_en && m_start) begin
            ep = rst_epoch;
            start_log.push_back(m_data);
            @(posedge clk);
            #1;
            checkOutput("start_pulse", 32'(m_start), 0);
            repeat (done_delay - 2) begin
                @(posedge clk);
                #1;
            end
            if (ep == rst_epoch) checkOutput("m_data_hold", 32'(m_data), 32'(start_log[$]));
            m_rdata = start_log[$] ^ KEY;
            m_done  = 1'b1;
            @(posedge clk);
            #1;
            m_done = 1'b0;
        end
    end

    initial begin
        int i;

        // Reset values while reset is held
        rst = 1'b1;
        #2;
        checkResetValues("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single transfer, latency and reply path
        master_en  = 1'b1;
        done_delay = 10;
        applyStimulus(8'hA5);
        checkOutput("lat_no_start_yet", 32'(m_start), 0);
        checkOutput("lat_tx_count", 32'(tx_count), 1);
        checkOutput("lat_busy", 32'(busy), 1);
        tick();
        checkOutput("lat_start", 32'(m_start), 1);
        checkOutput("lat_m_data", 32'(m_data), 'hA5);
        checkOutput("lat_tx_popped", 32'(tx_count), 0);
        waitRxCount(1, 30, "single");
        checkOutput("single_rx_data", 32'(rx_data), 'h3C);
        checkOutput("single_rx_valid", 32'(rx_valid), 1);
        checkOutput("single_rx_count", 32'(rx_count), 1);
        waitIdle(10, "single");
        popRx();
        checkOutput("single_popped", 32'(rx_count), 0);

        // Back-to-back burst fills the RX FIFO
        start_log.delete();
        done_delay = 4;
        for (int k = 1; k <= 8; k++) applyStimulus(8'(k));
        checkOutput("burst_tx_ready", 32'(tx_ready), 1);
        checkOutput("burst_tx_count", 32'(tx_count), 7);
        waitRxCount(8, 200, "burst");
        repeat (4) tick();
        checkOutput("burst_starts", start_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < start_log.size()) checkOutput("burst_order", 32'(start_log[k]), k + 1);
        end

        // RX full blocks the next launch until a pop frees a slot
        applyStimulus(8'h55);
        repeat (20) tick();
        checkOutput("full_no_start", start_log.size(), 8);
        checkOutput("full_tx_count", 32'(tx_count), 1);
        checkOutput("full_busy", 32'(busy), 1);
        checkOutput("full_rx_count", 32'(rx_count), 8);
        checkOutput("full_head", 32'(rx_data), 'h98);
        popRx();
        checkOutput("full_after_pop_count", 32'(rx_count), 7);
        checkOutput("full_after_pop_nostart", 32'(m_start), 0);
        tick();
        checkOutput("full_release_start", 32'(m_start), 1);
        checkOutput("full_release_data", 32'(m_data), 'h55);
        waitRxCount(8, 30, "refill");
        drain_exp = '{8'h9B, 8'h9A, 8'h9D, 8'h9C, 8'h9F, 8'h9E, 8'h91, 8'hCC};
        for (int k = 0; k < 8; k++) begin
            checkOutput("drain_data", 32'(rx_data), 32'(drain_exp[k]));
            popRx();
        end
        checkOutput("drain_empty", 32'(rx_count), 0);
        waitIdle(20, "drain");

        // Simultaneous RX push and pop keeps count and order
        done_delay = 6;
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        waitRxCount(2, 60, "simul_pre");
        waitIdle(20, "simul_pre");
        applyStimulus(8'h33);
        i = 0;
        while (i < 60) begin
            @(posedge clk);
            #2;
            if (m_done) break;
            i++;
        end
        if (i >= 60) checkOutput("simul_done_seen", 0, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        checkOutput("simul_count", 32'(rx_count), 2);
        checkOutput("simul_head", 32'(rx_data), 'hAB);
        popRx();
        checkOutput("simul_next", 32'(rx_data), 'hAA);
        popRx();
        checkOutput("simul_empty", 32'(rx_count), 0);
        waitIdle(20, "simul");

        // Timeout with no reply, then the queued byte proceeds
        master_en = 1'b0;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("to_start", 32'(m_start), 1);
        checkOutput("to_m_data", 32'(m_data), 'h11);
        tick();
        repeat (TIMEOUT - 1) tick();
        checkOutput("to_not_yet", 32'(timeout_err), 0);
        tick();
        checkOutput("to_set", 32'(timeout_err), 1);
        checkOutput("to_rx_count", 32'(rx_count), 0);
        checkOutput("to_tx_count", 32'(tx_count), 1);
        tick();
        master_en = 1'b1;
        tick();
        checkOutput("to_gap_nostart", 32'(m_start), 0);
        tick();
        checkOutput("to_next_start", 32'(m_start), 1);
        checkOutput("to_next_data", 32'(m_data), 'h22);
        waitRxCount(1, 30, "to_next");
        checkOutput("to_next_rx", 32'(rx_data), 'hBB);
        checkOutput("to_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("to_cleared", 32'(timeout_err), 0);
        popRx();
        waitIdle(20, "to");

        // Asynchronous reset mid-transfer; the late reply is dropped
        start_log.delete();
        done_delay = 20;
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        applyStimulus(8'h63);
        applyStimulus(8'h64);
        checkOutput("mid_tx_count", 32'(tx_count), 3);
        checkOutput("mid_m_data", 32'(m_data), 'h61);
        #3;
        rst = 1'b1;
        rst_epoch++;
        #1;
        checkResetValues("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) tick();
        checkOutput("post_rst_rx_count", 32'(rx_count), 0);
        checkOutput("post_rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("post_rst_starts", start_log.size(), 1);
        checkOutput("post_rst_busy", 32'(busy), 0);

        // m_done while idle is ignored
        stray_seq++;
        repeat (4) tick();
        checkOutput("stray_rx_count", 32'(rx_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_stream_ctrl.md
SPI_STREAM_CTRL -- requirements
Module: spi_stream_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per TX/RX FIFO (power of two, >= 2).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle clocks inserted after each transfer completes (>= 1).
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning max clocks waiting for m_done before aborting.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_ready  output  1  TX FIFO can accept.
REQ-009 SHALL have port rx_data  output  8  head of RX FIFO (show-ahead).
REQ-010 SHALL have port rx_valid  output  1  RX FIFO non-empty.
REQ-011 SHALL have port rx_ready  input  1  consumer pops RX head.
REQ-012 SHALL have port m_start  output  1  start pulse to SPI master.
REQ-013 SHALL have port m_data  output  8  byte to SPI master.
REQ-014 SHALL have port m_done  input  1  SPI master transfer complete pulse.
REQ-015 SHALL have port m_rdata  input  8  byte received by SPI master, valid with m_done.
REQ-016 SHALL have port busy  output  1  transfer pending or in progress.
REQ-017 SHALL have ports tx_count, rx_count  output  $clog2(DEPTH)+1 each  FIFO occupancy.
REQ-018 SHALL have port err_clr  input  1  clears timeout_err.
REQ-019 SHALL have port timeout_err  output  1  sticky: a transfer timed out.

Function
REQ-020 TX push SHALL occur on a rising edge with tx_valid && tx_ready; tx_ready = (tx_count < DEPTH); a push while full SHALL NOT happen even if the same cycle pops.
REQ-021 RX pop SHALL occur on a rising edge with rx_valid && rx_ready; simultaneous RX push and pop SHALL leave rx_count unchanged and preserve order.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL range 0..DEPTH inclusive.
REQ-023 FSM states SHALL be IDLE, START, WAIT, GAP.
REQ-024 IDLE -> START when tx_count > 0 and rx_count < DEPTH (RX space reserved before any transfer); on that edge the TX head SHALL be popped into m_data and m_start registered high.
REQ-025 m_start SHALL be high for exactly one clock (the START state); START -> WAIT unconditionally.
REQ-026 m_data SHALL hold stable from START until the FSM leaves WAIT.
REQ-027 In WAIT, m_done high SHALL push m_rdata into RX FIFO on that edge and go to GAP.
REQ-028 In WAIT, a wait counter SHALL increment each clock; reaching TIMEOUT without m_done SHALL set timeout_err, push nothing, go to GAP.
REQ-029 GAP SHALL last exactly GAP_CYCLES clocks, then return to IDLE.
REQ-030 m_done outside WAIT SHALL be ignored.
REQ-031 Latency: byte pushed into empty TX FIFO at edge E0 with RX space SHALL give m_start high after edge E1.
REQ-032 busy = (state != IDLE) || (tx_count > 0).
REQ-033 timeout_err SHALL clear on err_clr; if err_clr and a new timeout coincide, set SHALL win.

Reset
REQ-034 rst high SHALL immediately force: state IDLE, both FIFOs empty, tx_count = rx_count = 0, tx_ready = 1, rx_valid = 0, m_start = 0, m_data = 0x00, busy = 0, timeout_err = 0, counters 0.
REQ-035 Reset mid-transfer SHALL discard the in-flight byte; a later m_done SHALL be ignored.

Verification
REQ-036 Push 0xA5 into idle block, master returns m_rdata 0x3C with m_done 10 clocks after m_start -> m_start one clock after push edge, m_data 0xA5, rx_data 0x3C, rx_valid 1, rx_count 1.
REQ-037 Push 8 bytes 0x01..0x08 back-to-back, rx_ready 0 -> tx_ready 0 after 8th push only if no pop yet; 8 transfers in order, then rx_count 8, no further m_start until RX pop.
REQ-038 With rx_count 8, push 0x55 -> no m_start; pop one RX byte -> m_start with m_data 0x55 one clock after pop edge.
REQ-039 m_done never returned, TIMEOUT=1023 -> timeout_err high 1023 clocks after entering WAIT, rx_count unchanged, GAP then next TX byte started; err_clr -> timeout_err 0.
REQ-040 rst pulsed while in WAIT with tx_count 3 -> all outputs at reset values asynchronously; m_done afterwards produces no RX push.
REQ-041 Simultaneous RX push (m_done) and pop with rx_count 2 -> rx_count stays 2, data order preserved.
